// File: rtl/shadow_stack_ctrl.sv
// Shadow-stack control stage in front of safe_region: pushes return addresses on calls,
// pops and checks them on returns, and latches a sticky fault on mismatch/underflow/overflow.
module shadow_stack_ctrl #(
   parameter int DEPTH = 256,
   parameter int DW    = $clog2(DEPTH) + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          call_valid,
   input  logic [31:0]   call_addr,
   input  logic          ret_valid,
   input  logic [31:0]   ret_addr,
   output logic          busy,
   output logic          sr_enop,
   output logic [7:0]    sr_op,
   output logic [31:0]   sr_wdata,
   input  logic [31:0]   sr_rdata,
   output logic          check_done,
   output logic          check_ok,
   output logic [DW-1:0] depth,
   output logic          fault,
   output logic [1:0]    fault_code,
   output logic [31:0]   fault_exp,
   output logic [31:0]   fault_act
);

   typedef enum logic [2:0] {DRAIN, IDLE, PUSH, POP, CMP, FAULT} state_t;

   localparam logic [DW-1:0] FULL   = DW'(DEPTH);
   localparam logic [7:0]    OP_PSH = 8'd1;
   localparam logic [7:0]    OP_POP = 8'd2;

   state_t        state, state_n;
   logic [DW-1:0] cnt, cnt_n;
   logic [31:0]   addr_q, addr_n;
   logic          busy_n, enop_n, done_n, ok_n, fault_n;
   logic [7:0]    op_n;
   logic [31:0]   wdata_n, exp_n, act_n;
   logic [DW-1:0] depth_n;
   logic [1:0]    code_n;

   // Every output is computed here as its next value and registered below,
   // so the registered outputs always line up with the registered state.
   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      addr_n  = addr_q;
      busy_n  = 1'b1;
      enop_n  = 1'b0;
      op_n    = 8'd0;
      wdata_n = sr_wdata;
      done_n  = 1'b0;
      ok_n    = check_ok;
      depth_n = depth;
      fault_n = fault;
      code_n  = fault_code;
      exp_n   = fault_exp;
      act_n   = fault_act;
      case (state)
         DRAIN: begin
            if (cnt == FULL) begin
               state_n = IDLE;
               busy_n  = 1'b0;
               depth_n = '0;
               cnt_n   = '0;
            end else begin
               enop_n = 1'b1;
               op_n   = OP_POP;
               cnt_n  = cnt + 1'b1;
            end
         end
         IDLE: begin
            busy_n = 1'b0;
            if (call_valid) begin
               busy_n = 1'b1;
               if (depth == FULL) begin
                  state_n = FAULT;
                  fault_n = 1'b1;
                  code_n  = 2'd3;
                  act_n   = call_addr;
               end else begin
                  state_n = PUSH;
                  addr_n  = call_addr;
                  enop_n  = 1'b1;
                  op_n    = OP_PSH;
                  wdata_n = call_addr;
               end
            end else if (ret_valid) begin
               busy_n = 1'b1;
               if (depth == '0) begin
                  state_n = FAULT;
                  fault_n = 1'b1;
                  code_n  = 2'd2;
                  act_n   = ret_addr;
               end else begin
                  state_n = POP;
                  addr_n  = ret_addr;
                  enop_n  = 1'b1;
                  op_n    = OP_POP;
               end
            end
         end
         PUSH: begin
            state_n = IDLE;
            busy_n  = 1'b0;
            depth_n = depth + 1'b1;
         end
         POP: begin
            state_n = CMP;
            depth_n = depth - 1'b1;
         end
         CMP: begin
            done_n = 1'b1;
            ok_n   = (sr_rdata == addr_q);
            if (sr_rdata == addr_q) begin
               state_n = IDLE;
               busy_n  = 1'b0;
            end else begin
               state_n = FAULT;
               fault_n = 1'b1;
               code_n  = 2'd1;
               exp_n   = sr_rdata;
               act_n   = addr_q;
            end
         end
         default: ;  // FAULT: absorbing, everything held
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= DRAIN;
         cnt        <= '0;
         addr_q     <= '0;
         busy       <= 1'b1;
         sr_enop    <= 1'b0;
         sr_op      <= 8'd0;
         sr_wdata   <= '0;
         check_done <= 1'b0;
         check_ok   <= 1'b0;
         depth      <= '0;
         fault      <= 1'b0;
         fault_code <= 2'd0;
         fault_exp  <= '0;
         fault_act  <= '0;
      end else begin
         state      <= state_n;
         cnt        <= cnt_n;
         addr_q     <= addr_n;
         busy       <= busy_n;
         sr_enop    <= enop_n;
         sr_op      <= op_n;
         sr_wdata   <= wdata_n;
         check_done <= done_n;
         check_ok   <= ok_n;
         depth      <= depth_n;
         fault      <= fault_n;
         fault_code <= code_n;
         fault_exp  <= exp_n;
         fault_act  <= act_n;
      end
   end

endmodule

// File: tb/tb_shadow_stack_ctrl.sv
// Directed bench for shadow_stack_ctrl with a behavioural safe_region stack attached.
module tb_shadow_stack_ctrl;

   localparam int DEPTH = 256;
   localparam int DW    = $clog2(DEPTH) + 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          call_valid = 1'b0, ret_valid = 1'b0;
   logic [31:0]   call_addr = '0, ret_addr = '0;
   logic          busy, sr_enop, check_done, check_ok, fault;
   logic [7:0]    sr_op;
   logic [31:0]   sr_wdata, sr_rdata, fault_exp, fault_act;
   logic [DW-1:0] depth;
   logic [1:0]    fault_code;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   shadow_stack_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
      .clk(clk), .rst(rst),
      .call_valid(call_valid), .call_addr(call_addr),
      .ret_valid(ret_valid), .ret_addr(ret_addr),
      .busy(busy), .sr_enop(sr_enop), .sr_op(sr_op), .sr_wdata(sr_wdata),
      .sr_rdata(sr_rdata), .check_done(check_done), .check_ok(check_ok),
      .depth(depth), .fault(fault), .fault_code(fault_code),
      .fault_exp(fault_exp), .fault_act(fault_act)
   );

   // Behavioural safe_region: index is never reset, pops at index 0 are ignored.
   logic [31:0] mem [0:DEPTH-1];
   int          sidx = 7;
   always @(posedge clk) begin
      if (sr_enop) begin
         if (sr_op == 8'd1 && sidx < DEPTH) begin
            mem[sidx] <= sr_wdata;
            sidx      <= sidx + 1;
         end else if (sr_op == 8'd2 && sidx != 0) begin
            sr_rdata <= mem[sidx-1];
            sidx     <= sidx - 1;
         end
      end
   end

   task automatic run_drain(output int pulses, output int fell);
      pulses = 0;
      fell   = 0;
      for (int e = 1; e <= 400; e++) begin
         @(posedge clk); #1;
         if (sr_enop && sr_op == 8'd2) pulses++;
         if (!busy) begin
            fell = e;
            break;
         end
      end
   endtask

   task automatic reset_and_drain();
      int p, f;
      @(negedge clk);
      rst = 1'b1; call_valid = 1'b0; ret_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      run_drain(p, f);
      n_checks++;
      if (f == 0) begin n_fail++; $display("FAIL drain_timeout: busy never fell"); end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy: got %b want 1", busy); end
      n_checks++;
      if ({sr_enop, sr_op, sr_wdata} !== '0) begin n_fail++;
         $display("FAIL reset_sr: got enop=%b op=%0d wdata=%h want 0", sr_enop, sr_op, sr_wdata); end
      n_checks++;
      if ({check_done, check_ok, depth, fault, fault_code, fault_exp, fault_act} !== '0) begin n_fail++;
         $display("FAIL reset_status: got done=%b ok=%b depth=%0d fault=%b code=%0d want all 0",
                  check_done, check_ok, depth, fault, fault_code); end
   endtask

   task automatic test_drain();
      int p, f;
      @(negedge clk);
      rst = 1'b0;
      run_drain(p, f);
      n_checks++;
      if (p !== 256) begin n_fail++; $display("FAIL drain_pulses: got %0d want 256", p); end
      n_checks++;
      if (f !== 257) begin n_fail++; $display("FAIL drain_busy_edge: got %0d want 257", f); end
      n_checks++;
      if (depth !== '0 || sidx !== 0) begin n_fail++;
         $display("FAIL drain_depth: got depth=%0d sr_idx=%0d want 0/0", depth, sidx); end
   endtask

   task automatic test_match();
      @(negedge clk); call_valid = 1'b1; call_addr = 32'h0000_1004;
      @(posedge clk); #1;
      n_checks++;
      if (!(sr_enop === 1'b1 && sr_op === 8'd1 && sr_wdata === 32'h1004 && busy === 1'b1)) begin n_fail++;
         $display("FAIL match_push: got enop=%b op=%0d wdata=%h busy=%b want 1/1/1004/1",
                  sr_enop, sr_op, sr_wdata, busy); end
      @(negedge clk); call_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (!(busy === 1'b0 && depth === 9'd1 && sr_enop === 1'b0)) begin n_fail++;
         $display("FAIL match_after_push: got busy=%b depth=%0d enop=%b want 0/1/0", busy, depth, sr_enop); end
      @(negedge clk); ret_valid = 1'b1; ret_addr = 32'h0000_1004;
      @(posedge clk); #1;
      n_checks++;
      if (!(sr_enop === 1'b1 && sr_op === 8'd2)) begin n_fail++;
         $display("FAIL match_pop: got enop=%b op=%0d want 1/2", sr_enop, sr_op); end
      @(negedge clk); ret_valid = 1'b0;
      @(posedge clk); #1;
      n_checks++;
      if (!(check_done === 1'b0 && busy === 1'b1 && sr_enop === 1'b0)) begin n_fail++;
         $display("FAIL match_cmp: got done=%b busy=%b enop=%b want 0/1/0", check_done, busy, sr_enop); end
      @(posedge clk); #1;
      n_checks++;
      if (!(check_done === 1'b1 && check_ok === 1'b1 && depth === '0 && busy === 1'b0 && fault === 1'b0)) begin
         n_fail++;
         $display("FAIL match_result: got done=%b ok=%b depth=%0d busy=%b fault=%b want 1/1/0/0/0",
                  check_done, check_ok, depth, busy, fault); end
      @(posedge clk); #1;
      n_checks++;
      if (check_done !== 1'b0) begin n_fail++; $display("FAIL match_done_pulse: got %b want 0", check_done); end
   endtask

   task automatic test_mismatch();
      int pushes = 0;
      @(negedge clk); call_valid = 1'b1; call_addr = 32'h2000;
      @(posedge clk);
      @(negedge clk); call_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); ret_valid = 1'b1; ret_addr = 32'h2010;
      @(posedge clk);
      @(negedge clk); ret_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      n_checks++;
      if (!(check_done === 1'b1 && check_ok === 1'b0)) begin n_fail++;
         $display("FAIL mismatch_check: got done=%b ok=%b want 1/0", check_done, check_ok); end
      n_checks++;
      if (!(fault === 1'b1 && fault_code === 2'd1 && fault_exp === 32'h2000 && fault_act === 32'h2010)) begin
         n_fail++;
         $display("FAIL mismatch_fault: got fault=%b code=%0d exp=%h act=%h want 1/1/2000/2010",
                  fault, fault_code, fault_exp, fault_act); end
      @(negedge clk); call_valid = 1'b1; call_addr = 32'h5000;
      repeat (4) begin
         @(posedge clk); #1;
         if (sr_enop) pushes++;
      end
      call_valid = 1'b0;
      n_checks++;
      if (!(pushes == 0 && busy === 1'b1 && depth === '0 && fault_code === 2'd1 && fault_act === 32'h2010)) begin
         n_fail++;
         $display("FAIL mismatch_sticky: got enops=%0d busy=%b depth=%0d code=%0d act=%h want 0/1/0/1/2010",
                  pushes, busy, depth, fault_code, fault_act); end
   endtask

   task automatic test_underflow();
      int seen = 0;
      @(negedge clk); ret_valid = 1'b1; ret_addr = 32'h3000;
      @(posedge clk); #1;
      if (sr_enop) seen++;
      ret_valid = 1'b0;
      repeat (2) begin
         @(posedge clk); #1;
         if (sr_enop) seen++;
      end
      n_checks++;
      if (seen !== 0) begin n_fail++; $display("FAIL underflow_no_pop: got %0d enop cycles want 0", seen); end
      n_checks++;
      if (!(fault === 1'b1 && fault_code === 2'd2 && fault_act === 32'h3000 && busy === 1'b1 && check_done === 1'b0))
      begin
         n_fail++;
         $display("FAIL underflow_fault: got fault=%b code=%0d act=%h busy=%b done=%b want 1/2/3000/1/0",
                  fault, fault_code, fault_act, busy, check_done); end
   endtask

   task automatic test_overflow();
      int pushes = 0;
      int extra  = 0;
      for (int i = 0; i < DEPTH; i++) begin
         @(negedge clk); call_valid = 1'b1; call_addr = 32'h0010_0000 + i;
         @(posedge clk); #1;
         if (sr_enop && sr_op == 8'd1) pushes++;
         @(negedge clk); call_valid = 1'b0;
         @(posedge clk);
      end
      #1;
      n_checks++;
      if (!(pushes == DEPTH && depth === 9'd256 && sidx == DEPTH && fault === 1'b0)) begin n_fail++;
         $display("FAIL overflow_fill: got pushes=%0d depth=%0d sr_idx=%0d fault=%b want 256/256/256/0",
                  pushes, depth, sidx, fault); end
      @(negedge clk); call_valid = 1'b1; call_addr = 32'hDEAD_0000;
      repeat (3) begin
         @(posedge clk); #1;
         if (sr_enop) extra++;
      end
      call_valid = 1'b0;
      n_checks++;
      if (!(extra == 0 && fault === 1'b1 && fault_code === 2'd3 && fault_act === 32'hDEAD_0000 && depth === 9'd256))
      begin
         n_fail++;
         $display("FAIL overflow_fault: got enops=%0d fault=%b code=%0d act=%h depth=%0d want 0/1/3/dead0000/256",
                  extra, fault, fault_code, fault_act, depth); end
   endtask

   task automatic test_collision();
      @(negedge clk);
      call_valid = 1'b1; call_addr = 32'h4444;
      ret_valid  = 1'b1; ret_addr  = 32'h4444;
      @(posedge clk); #1;
      n_checks++;
      if (!(sr_enop === 1'b1 && sr_op === 8'd1 && sr_wdata === 32'h4444)) begin n_fail++;
         $display("FAIL collision_push_first: got enop=%b op=%0d wdata=%h want 1/1/4444", sr_enop, sr_op, sr_wdata); end
      @(negedge clk); call_valid = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      n_checks++;
      if (!(sr_enop === 1'b1 && sr_op === 8'd2 && depth === 9'd1)) begin n_fail++;
         $display("FAIL collision_pop: got enop=%b op=%0d depth=%0d want 1/2/1", sr_enop, sr_op, depth); end
      @(negedge clk); ret_valid = 1'b0;
      @(posedge clk);
      @(posedge clk); #1;
      n_checks++;
      if (!(check_done === 1'b1 && check_ok === 1'b1 && depth === '0 && fault === 1'b0)) begin n_fail++;
         $display("FAIL collision_result: got done=%b ok=%b depth=%0d fault=%b want 1/1/0/0",
                  check_done, check_ok, depth, fault); end
   endtask

   task automatic test_midop_reset();
      int p, f;
      @(negedge clk); call_valid = 1'b1; call_addr = 32'h6000;
      @(posedge clk);
      @(negedge clk); call_valid = 1'b0;
      @(posedge clk);
      @(negedge clk); ret_valid = 1'b1; ret_addr = 32'h6000;
      @(posedge clk); #1;
      n_checks++;
      if (!(sr_enop === 1'b1 && sr_op === 8'd2)) begin n_fail++;
         $display("FAIL midop_in_pop: got enop=%b op=%0d want 1/2", sr_enop, sr_op); end
      #1; rst = 1'b1; ret_valid = 1'b0;
      #1;
      n_checks++;
      if (!(sr_enop === 1'b0 && sr_op === 8'd0 && depth === '0 && busy === 1'b1 && check_done === 1'b0)) begin
         n_fail++;
         $display("FAIL midop_reset_outputs: got enop=%b op=%0d depth=%0d busy=%b done=%b want 0/0/0/1/0",
                  sr_enop, sr_op, depth, busy, check_done); end
      @(negedge clk); rst = 1'b0;
      run_drain(p, f);
      n_checks++;
      if (!(p == 256 && f == 257 && depth === '0 && sidx == 0)) begin n_fail++;
         $display("FAIL midop_redrain: got pulses=%0d edge=%0d depth=%0d sr_idx=%0d want 256/257/0/0",
                  p, f, depth, sidx); end
   endtask

   initial begin
      test_reset();
      test_drain();
      test_match();
      test_mismatch();
      reset_and_drain();
      test_underflow();
      reset_and_drain();
      test_overflow();
      reset_and_drain();
      test_collision();
      test_midop_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
